remote_send: RTL and testbench

NEC-format infrared transmitter, the transmit-side counterpart to the team's IR receiver. On a one-cycle request it serialises a full frame: 9 ms leader, 4.5 ms space, 32 bits {addr, ~addr, data, ~data} LSB first, and a stop burst. On a separate request it sends a repeat code instead. It drives a demodulated line `remote_out` (idle high, low during bursts) that is polarity-compatible with the receiver input for loopback, plus an `ir_led` drive for the emitter.

---
 rtl/remote_send.sv | 101 ++++++++++
 tb/tb_remote_send.sv | 134 +++++++++++++
 2 files changed

// File: rtl/remote_send.sv
// remote_send: NEC IR transmitter (full frame or repeat code), registered outputs.
// Optional `IR_CARRIER_EN: ir_led carries a 38 kHz burst instead of the plain mark level.
module remote_send #(
  parameter int UNIT_CYC    = 28125,
  parameter int GAP_UNITS   = 72,
  parameter int CARRIER_DIV = 1316
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       send_en,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       remote_out,
  output logic       ir_led
);
  localparam logic [2:0] IDLE = 3'd0, LEAD_LOW = 3'd1, LEAD_HIGH = 3'd2, BIT_LOW = 3'd3,
                         BIT_HIGH = 3'd4, STOP_LOW = 3'd5, GAP = 3'd6;
  localparam int CW = UNIT_CYC > 1 ? $clog2(UNIT_CYC) : 1;
  logic [2:0] state, nxt;
  logic [CW-1:0] cyc_cnt;
  logic [6:0] unit_cnt, target;
  logic [5:0] bit_cnt;
  logic [31:0] shreg;
  logic is_rep, tick, last, accept, nxt_mark;
  always_comb begin
    tick = cyc_cnt == CW'(UNIT_CYC - 1);
    target = state == LEAD_LOW  ? 7'd16 :
             state == LEAD_HIGH ? (is_rep ? 7'd4 : 7'd8) :
             state == BIT_HIGH  ? (shreg[0] ? 7'd3 : 7'd1) :
             state == GAP       ? 7'(GAP_UNITS) : 7'd1;
    last = tick && unit_cnt == target - 7'd1;
    accept = state == IDLE && (send_en || repeat_req);
    nxt = state;
    case (state)
      IDLE:      nxt = accept ? LEAD_LOW : IDLE;
      LEAD_LOW:  nxt = last ? LEAD_HIGH : state;
      LEAD_HIGH: nxt = last ? (is_rep ? STOP_LOW : BIT_LOW) : state;
      BIT_LOW:   nxt = last ? BIT_HIGH : state;
      BIT_HIGH:  nxt = last ? (bit_cnt == 6'd31 ? STOP_LOW : BIT_LOW) : state;
      STOP_LOW:  nxt = last ? GAP : state;
      GAP:       nxt = last ? IDLE : state;
      default:   nxt = IDLE;
    endcase
    nxt_mark = nxt == LEAD_LOW || nxt == BIT_LOW || nxt == STOP_LOW;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      remote_out <= 1'b1;
      cyc_cnt    <= '0;
      unit_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      is_rep     <= 1'b0;
    end else begin
      state      <= nxt;
      remote_out <= !nxt_mark;
      busy       <= nxt != IDLE;
      done       <= state == GAP && last;
      if (accept) begin
        shreg    <= {~data, data, ~addr, addr};
        is_rep   <= repeat_req && !send_en;
        bit_cnt  <= '0;
        cyc_cnt  <= '0;
        unit_cnt <= '0;
      end else if (state != IDLE) begin
        cyc_cnt  <= tick ? '0 : cyc_cnt + 1'b1;
        unit_cnt <= last ? 7'd0 : tick ? unit_cnt + 7'd1 : unit_cnt;
        if (state == BIT_HIGH && last) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end
`ifdef IR_CARRIER_EN
  localparam int KW = CARRIER_DIV > 1 ? $clog2(CARRIER_DIV) : 1;
  logic [KW-1:0] car_cnt, car_nxt;
  // restart on every space-to-mark edge so each burst opens with a high phase
  always_comb car_nxt = (nxt_mark && remote_out) || car_cnt == KW'(CARRIER_DIV - 1) ? '0 : car_cnt + 1'b1;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      car_cnt <= '0;
      ir_led  <= 1'b0;
    end else begin
      car_cnt <= car_nxt;
      ir_led  <= nxt_mark && car_nxt < KW'(CARRIER_DIV / 3);
    end
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ir_led <= 1'b0;
    else ir_led <= nxt_mark;
  end
`endif
endmodule

// File: tb/tb_remote_send.sv
// tb_remote_send: table-driven check of remote_send waveforms at UNIT_CYC=4, GAP_UNITS=2.
module tb_remote_send;
  localparam int U = 4;
  typedef struct {
    logic       snd;
    logic       rep;
    logic [7:0] a;
    logic [7:0] d;
    int         blen;
    int         poke;
  } vec_t;
  logic sys_clk = 0, sys_rst_n = 0, send_en = 0, repeat_req = 0;
  logic [7:0] addr = 0, data = 0;
  logic busy, done, remote_out, ir_led;
  int checks = 0, failures = 0;
  logic exp_w [0:1023];
  int exp_len;
  vec_t vt [0:4];

  remote_send #(.UNIT_CYC(U), .GAP_UNITS(2), .CARRIER_DIV(6)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .send_en(send_en), .repeat_req(repeat_req),
    .addr(addr), .data(data), .busy(busy), .done(done), .remote_out(remote_out), .ir_led(ir_led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic push(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      exp_w[exp_len] = v;
      exp_len++;
    end
  endtask

  task automatic build(input logic frame, input logic [7:0] a, input logic [7:0] d);
    logic [31:0] w;
    w = {~d, d, ~a, a};
    exp_len = 0;
    push(0, 16 * U);
    push(1, (frame ? 8 : 4) * U);
    if (frame)
      for (int k = 0; k < 32; k++) begin
        push(0, U);
        push(1, (w[k] ? 3 : 1) * U);
      end
    push(0, U);
    push(1, 2 * U);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int bad, first, got_ro, got_led, want_ro, want_led, bcnt, dcnt, dpos, after, j;
    build(v.snd, v.a, v.d);
    bad = 0; first = -1; got_ro = 0; got_led = 0; want_ro = 0; want_led = 0;
    bcnt = 0; dcnt = 0; dpos = -1; after = 0; j = 0;
    @(negedge sys_clk);
    send_en = v.snd; repeat_req = v.rep; addr = v.a; data = v.d;
    @(negedge sys_clk);
    send_en = 0; repeat_req = 0; addr = ~v.a; data = ~v.d;
    for (int i = 0; i < exp_len + 24; i++) begin
      logic er, el;
      if (i > 0) @(negedge sys_clk);
      if (i == v.poke) begin send_en = 1; addr = 8'h5A; data = 8'hC3; end
      if (i == v.poke + 1) send_en = 0;
      er = i < exp_len ? exp_w[i] : 1'b1;
      j = (!er && i > 0 && !exp_w[i-1]) ? j + 1 : 0;
`ifdef IR_CARRIER_EN
      el = !er && (j % 6) < 2;
`else
      el = !er;
`endif
      if ((remote_out !== er || ir_led !== el) && first < 0) begin
        first = i; got_ro = remote_out; got_led = ir_led; want_ro = er; want_led = el;
      end
      if (remote_out !== er || ir_led !== el) bad++;
      if (busy) bcnt++;
      if (busy && i > exp_len) after++;
      if (done) begin dcnt++; dpos = i; end
    end
    if (bad != 0)
      $display("FAIL wave[%0d] at cycle %0d: remote_out=%0d ir_led=%0d expected %0d %0d",
               id, first, got_ro, got_led, want_ro, want_led);
    chk($sformatf("wave_mismatches[%0d]", id), bad, 0);
    chk($sformatf("busy_len[%0d]", id), bcnt, v.blen);
    chk($sformatf("done_count[%0d]", id), dcnt, 1);
    chk($sformatf("done_pos[%0d]", id), dpos, v.blen);
    chk($sformatf("busy_after[%0d]", id), after, 0);
  endtask

  initial begin
    vt[0] = '{snd: 1, rep: 0, a: 8'h00, d: 8'h45, blen: 492, poke: -1};
    vt[1] = '{snd: 0, rep: 1, a: 8'h00, d: 8'h00, blen: 92,  poke: -1};
    vt[2] = '{snd: 1, rep: 1, a: 8'hA5, d: 8'h3C, blen: 492, poke: 150};
    vt[3] = '{snd: 1, rep: 0, a: 8'hFF, d: 8'h00, blen: 492, poke: -1};
    vt[4] = '{snd: 0, rep: 1, a: 8'h12, d: 8'h34, blen: 92,  poke: 40};
    repeat (2) @(negedge sys_clk);
    chk("rst_remote_out", remote_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ir_led", ir_led, 0);
    sys_rst_n = 1;
    repeat (3) @(negedge sys_clk);
    for (int n = 0; n < 5; n++) run_vec(vt[n], n);
    // bit 10 of a 0x00/0x45 frame: its space spans cycles 196..207 after acceptance
    @(negedge sys_clk);
    send_en = 1; addr = 8'h00; data = 8'h45;
    @(negedge sys_clk);
    send_en = 0;
    repeat (200) @(negedge sys_clk);
    chk("pre_rst_busy", busy, 1);
    sys_rst_n = 0;
    #1;
    chk("midrst_remote_out", remote_out, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ir_led", ir_led, 0);
    begin
      int dseen;
      dseen = done;
      repeat (3) begin @(negedge sys_clk); dseen += done; end
      sys_rst_n = 1;
      repeat (20) begin @(negedge sys_clk); dseen += done + busy; end
      chk("midrst_no_done", dseen, 0);
    end
    run_vec(vt[0], 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
